// File: rtl/antirebote_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
//   DIV_DEF     : default clk cycles per sampling tick
//   ESTABLE_DEF : default number of stable ticks before an output changes
//   clog2(v)    : bits needed to hold the values 0..v-1 (minimum 1)
package antirebote_pkg;

  localparam int unsigned DIV_DEF     = 5000000;
  localparam int unsigned ESTABLE_DEF = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/antirebote_multi_divisor_tick.sv
// Prescaler producing a one-cycle sampling strobe every DIV clk cycles.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   tick : registered strobe, high for one cycle when the count wraps
module divisor_tick #(
  parameter int unsigned DIV   = 5000000,
  parameter int unsigned DIV_W = 23
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_cuenta;
  logic             r_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cuenta <= '0;
      r_tick   <= 1'b0;
    end else if (r_cuenta == LAST) begin
      r_cuenta <= '0;
      r_tick   <= 1'b1;
    end else begin
      r_cuenta <= r_cuenta + 1'b1;
      r_tick   <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/antirebote_multi.sv
// Multi-channel debouncer: two-flop synchroniser per channel, a shared
// sampling prescaler and a saturating stability counter per channel.
// Ports:
//   clk  : system clock (single domain)
//   rst  : asynchronous active-high reset
//   in   : raw bouncing inputs, CH bits
//   out  : debounced levels, CH bits
//   sube : one-cycle pulse when out[i] rises
//   baja : one-cycle pulse when out[i] falls
//   tick : sampling strobe, exported for neighbouring blocks
module antirebote_multi
  import antirebote_pkg::*;
#(
  parameter int unsigned CH      = 4,
  parameter int unsigned DIV     = DIV_DEF,
  parameter int unsigned DIV_W   = 23,
  parameter int unsigned ESTABLE = ESTABLE_DEF,
  parameter int unsigned CNT_W   = 3,
  parameter logic        INIT    = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] out,
  output logic [CH-1:0] sube,
  output logic [CH-1:0] baja,
  output logic          tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ESTABLE - 1);

  logic          w_tick;
  logic [CH-1:0] r_sync1;
  logic [CH-1:0] r_sync2;
  logic [CH-1:0] w_s;

  divisor_tick #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_divisor_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign tick = w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= {CH{INIT}};
      r_sync2 <= {CH{INIT}};
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_sube;
    logic             r_baja;

    // Counter only advances while the sampled level differs from out; any
    // tick seeing the old level restarts qualification. Pulses self-clear
    // because ticks are never back to back (DIV >= 2).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt  <= '0;
        r_out  <= INIT;
        r_sube <= 1'b0;
        r_baja <= 1'b0;
      end else begin
        r_sube <= 1'b0;
        r_baja <= 1'b0;
        if (w_tick) begin
          if (w_s[i] == r_out) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_out  <= w_s[i];
            r_cnt  <= '0;
            r_sube <= w_s[i];
            r_baja <= ~w_s[i];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end

    assign out[i]  = r_out;
    assign sube[i] = r_sube;
    assign baja[i] = r_baja;
  end

endmodule

// File: tb/tb_antirebote_multi.sv
module tb_antirebote_multi;
  import antirebote_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [3:0] out;
  logic [3:0] sube;
  logic [3:0] baja;
  logic       tick;

  int n_tests;
  int n_fail;
  int cyc;

  antirebote_multi #(
    .CH      (4),
    .DIV     (4),
    .DIV_W   (clog2(4)),
    .ESTABLE (3),
    .CNT_W   (clog2(3)),
    .INIT    (1'b0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .out  (out),
    .sube (sube),
    .baja (baja),
    .tick (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] e_out, e_sube, e_baja;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    in      = 4'b0000;

    repeat (3) begin
      @(posedge clk);
    end
    #1;
    chk("rst_out",  32'(out),  32'h0);
    chk("rst_sube", 32'(sube), 32'h0);
    chk("rst_baja", 32'(baja), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);

    // Release reset just after an edge: this is cycle 0.
    rst = 1'b0;
    cyc = 0;

    // Press on ch0/ch2, bounce on ch1, then release ch0 + press ch3 together,
    // then start a fall on ch2 that reset will interrupt.
    for (int k = 1; k <= 42; k++) begin
      adv();
      if (k == 1)  in = 4'b0111;
      if (k == 9)  in = 4'b0101;
      if (k == 17) in = 4'b1100;
      if (k == 31) in = 4'b1000;
      e_out  = (k < 13) ? 4'b0000 : (k < 29) ? 4'b0101 : 4'b1100;
      e_sube = (k == 13) ? 4'b0101 : (k == 29) ? 4'b1000 : 4'b0000;
      e_baja = (k == 29) ? 4'b0001 : 4'b0000;
      chk("tick", 32'(tick), 32'((k % 4) == 0));
      chk("out",  32'(out),  32'(e_out));
      chk("sube", 32'(sube), 32'(e_sube));
      chk("baja", 32'(baja), 32'(e_baja));
    end

    // Asynchronous reset in the middle of cycle 42, after two qualifying ticks.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out",  32'(out),  32'h0);
    chk("arst_sube", 32'(sube), 32'h0);
    chk("arst_baja", 32'(baja), 32'h0);
    chk("arst_tick", 32'(tick), 32'h0);
    in = 4'b1100;
    @(posedge clk);
    #1;
    chk("hold_out",  32'(out),  32'h0);
    chk("hold_tick", 32'(tick), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Inputs already differ from INIT at release: full requalification.
    for (int k = 1; k <= 16; k++) begin
      adv();
      e_out  = (k < 13) ? 4'b0000 : 4'b1100;
      e_sube = (k == 13) ? 4'b1100 : 4'b0000;
      chk("r_tick", 32'(tick), 32'((k % 4) == 0));
      chk("r_out",  32'(out),  32'(e_out));
      chk("r_sube", 32'(sube), 32'(e_sube));
      chk("r_baja", 32'(baja), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
